// File: rtl/tmp_pkg.sv
// ---------------------------------------------------------------------------
// tmp_pkg -- shared definitions for the temperature-sensor decimator.
//
// Holds the decimator FSM state encoding and the default window / settle
// parameters so the top level and the ones counter agree on them.
// ---------------------------------------------------------------------------
package tmp_pkg;

  // Default window length is 2^OSR_LOG2_DEF comparator decisions.
  localparam int OSR_LOG2_DEF = 8;
  // Default number of leading decisions discarded after enable.
  localparam int SETTLE_DEF   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCUM  = 2'd2
  } tmp_state_e;

endpackage : tmp_pkg

// File: rtl/tmp_ones_counter.sv
// ---------------------------------------------------------------------------
// tmp_ones_counter -- strobe-gated window counter and ones accumulator.
//
// Counts strobes over a window of 2^OSR_LOG2 decisions and sums the decision
// bits. On the strobe that completes the window, o_done pulses and o_sum
// carries the final sum including that strobe's bit; the counter and
// accumulator restart on the same edge, so the next strobe opens a new window.
//
// Ports:
//   clk      in   clock, posedge
//   reset_n  in   asynchronous active-low reset
//   i_clear  in   synchronous clear of counter and accumulator (wins over i_stb)
//   i_stb    in   valid decision strobe
//   i_bit    in   decision bit, used only when i_stb=1
//   o_done   out  this strobe completes the window (combinational)
//   o_sum    out  accumulator plus current bit (CODE_W bits)
// ---------------------------------------------------------------------------
module tmp_ones_counter
  import tmp_pkg::*;
#(
  parameter int OSR_LOG2 = OSR_LOG2_DEF,
  parameter int CODE_W   = OSR_LOG2 + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_clear,
  input  logic              i_stb,
  input  logic              i_bit,
  output logic              o_done,
  output logic [CODE_W-1:0] o_sum
);

  logic [OSR_LOG2-1:0] r_cnt;
  logic [CODE_W-1:0]   r_acc;
  logic                w_last;

  // The accumulator holds at most 2^OSR_LOG2-1 before the final strobe, so
  // the sum including the last bit peaks at 2^OSR_LOG2 and never wraps.
  assign w_last = &r_cnt;
  assign o_sum  = r_acc + CODE_W'(i_bit);
  assign o_done = i_stb & w_last & ~i_clear;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (i_stb) begin
      // r_cnt wraps from all-ones to zero, which is exactly the restart.
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_last ? '0 : o_sum;
    end
  end

endmodule : tmp_ones_counter

// File: rtl/tmp_decimator.sv
// ---------------------------------------------------------------------------
// tmp_decimator -- decimates a comparator bit stream into a ones count.
//
// After enable, SETTLE strobes are discarded, then every window of
// 2^OSR_LOG2 strobes produces a count of ones offered on a valid/ready
// interface. A result that completes while an earlier one is still unconsumed
// is dropped and flagged with a sticky overrun.
//
// Ports:
//   clk         in   clock, posedge
//   reset_n     in   asynchronous active-low reset
//   enable      in   1 = convert continuously, 0 = abort and idle
//   bit_stb     in   one-cycle strobe marking a valid comparator decision
//   cmp_bit     in   comparator decision, sampled when bit_stb=1
//   code        out  ones count of the last completed window
//   code_valid  out  code holds an unconsumed result
//   code_ready  in   consumer accepts code when code_valid & code_ready
//   busy        out  converter is settling or accumulating
//   overrun     out  sticky: a completed window was dropped
// ---------------------------------------------------------------------------
module tmp_decimator
  import tmp_pkg::*;
#(
  parameter int OSR_LOG2 = OSR_LOG2_DEF,
  parameter int SETTLE   = SETTLE_DEF,
  parameter int CODE_W   = OSR_LOG2 + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              bit_stb,
  input  logic              cmp_bit,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              busy,
  output logic              overrun
);

  // Wide enough for SETTLE-1; at least one bit so SETTLE=0 still elaborates.
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'((SETTLE > 0) ? SETTLE - 1 : 0);

  tmp_state_e        r_state;
  tmp_state_e        w_state_nxt;
  logic              w_start;
  logic [SET_W-1:0]  r_settle_cnt;
  logic              w_cnt_clear;
  logic              w_done;
  logic [CODE_W-1:0] w_sum;
  logic [CODE_W-1:0] r_code;
  logic              r_code_valid;
  logic              r_overrun;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_start     = 1'b1;
          w_state_nxt = (SETTLE == 0) ? ST_ACCUM : ST_SETTLE;
        end
        ST_SETTLE: begin
          if (bit_stb && (r_settle_cnt == SETTLE_LAST)) begin
            w_state_nxt = ST_ACCUM;
          end
        end
        ST_ACCUM: w_state_nxt = ST_ACCUM;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: all state, including counters and the held result, is cleared by
  // the asynchronous reset so outputs drop without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_settle_cnt <= '0;
      end else if ((r_state == ST_SETTLE) && enable && bit_stb) begin
        r_settle_cnt <= r_settle_cnt + 1'b1;
      end
    end
  end

  // The window only runs while accumulating and enabled; anything else keeps
  // it cleared, which discards a partial window and ignores a strobe in the
  // cycle enable drops.
  assign w_cnt_clear = (r_state != ST_ACCUM) | ~enable;

  tmp_ones_counter #(
    .OSR_LOG2 (OSR_LOG2),
    .CODE_W   (CODE_W)
  ) u_ones_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (w_cnt_clear),
    .i_stb   (bit_stb),
    .i_bit   (cmp_bit),
    .o_done  (w_done),
    .o_sum   (w_sum)
  );

  // Output holding register. A completing window loads if the slot is empty
  // or being consumed this very cycle; otherwise it is dropped and flagged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_start) begin
        r_overrun <= 1'b0;
      end
      if (w_done) begin
        if (!r_code_valid || code_ready) begin
          r_code       <= w_sum;
          r_code_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_code_valid && code_ready) begin
        r_code_valid <= 1'b0;
      end
    end
  end

  assign code       = r_code;
  assign code_valid = r_code_valid;
  assign overrun    = r_overrun;
  assign busy       = (r_state != ST_IDLE);

endmodule : tmp_decimator

// File: tb/tb_tmp_decimator.sv
// ---------------------------------------------------------------------------
// tb_tmp_decimator -- self-checking bench for tmp_decimator with a window of
// 8 decisions and 2 settle decisions. A behavioural model pushes expected
// window sums into a queue as stimulus is applied; a negedge monitor pops
// and compares them whenever the DUT hands a code over.
// ---------------------------------------------------------------------------
module tb_tmp_decimator;

  localparam int OSR_LOG2 = 3;
  localparam int SETTLE   = 2;
  localparam int CODE_W   = OSR_LOG2 + 1;
  localparam int WIN      = 1 << OSR_LOG2;

  logic              clk;
  logic              reset_n;
  logic              enable;
  logic              bit_stb;
  logic              cmp_bit;
  logic              code_ready;
  logic [CODE_W-1:0] code;
  logic              code_valid;
  logic              busy;
  logic              overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  // Behavioural model: phase 0 idle, 1 settling, 2 accumulating.
  int m_phase   = 0;
  int m_settle  = 0;
  int m_n       = 0;
  int m_sum     = 0;
  int m_last    = 0;
  bit m_valid   = 1'b0;
  bit m_overrun = 1'b0;
  bit rst_evt   = 1'b0;

  tmp_decimator #(
    .OSR_LOG2 (OSR_LOG2),
    .SETTLE   (SETTLE),
    .CODE_W   (CODE_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .bit_stb    (bit_stb),
    .cmp_bit    (cmp_bit),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_phase   = 0;
    m_settle  = 0;
    m_n       = 0;
    m_sum     = 0;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
    exp_q.delete();
  endtask

  // Apply inputs for one clock, then advance the model past that edge.
  task automatic cycle(input bit en, input bit stb, input bit b, input bit rdy);
    bit accept;
    bit done;
    int val;
    enable     = en;
    bit_stb    = stb;
    cmp_bit    = b;
    code_ready = rdy;
    @(posedge clk);
    #1;
    accept = m_valid && rdy;
    done   = 1'b0;
    val    = 0;
    if (!en) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: begin
          m_overrun = 1'b0;
          m_settle  = 0;
          m_n       = 0;
          m_sum     = 0;
          m_phase   = (SETTLE == 0) ? 2 : 1;
        end
        1: if (stb) begin
          m_settle++;
          if (m_settle == SETTLE) m_phase = 2;
        end
        default: if (stb) begin
          m_sum += int'(b);
          m_n++;
          if (m_n == WIN) begin
            done  = 1'b1;
            val   = m_sum;
            m_n   = 0;
            m_sum = 0;
          end
        end
      endcase
    end
    if (done) begin
      if (!m_valid || rdy) begin
        exp_q.push_back(val);
        m_valid = 1'b1;
        m_last  = val;
      end else begin
        m_overrun = 1'b1;
      end
    end else if (accept) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic strobe(input bit b, input bit rdy);
    cycle(1'b1, 1'b1, b, rdy);
  endtask

  // Monitor: compare status against the model, pop the scoreboard on every
  // handshake, and require a stalled code to stay put.
  int prev_code = 0;
  bit prev_hold = 1'b0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_hold && !rst_evt) begin
        check("hold_valid", int'(code_valid), 1);
        check("hold_code", int'(code), prev_code);
      end
      rst_evt = 1'b0;
      check("valid", int'(code_valid), int'(m_valid));
      check("overrun", int'(overrun), int'(m_overrun));
      check("busy", int'(busy), int'(m_phase != 0));
      if (code_valid && code_ready) begin
        if (exp_q.size() == 0) check("sb_has_entry", exp_q.size(), 1);
        else check("code", int'(code), exp_q.pop_front());
      end
      prev_hold = code_valid && !code_ready;
      prev_code = int'(code);
    end
  end

  initial begin
    bit b;
    reset_n    = 1'b1;
    enable     = 1'b0;
    bit_stb    = 1'b0;
    cmp_bit    = 1'b0;
    code_ready = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    check("rst_code", int'(code), 0);
    check("rst_valid", int'(code_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    #10 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // All-ones window: code=8 one cycle after the 10th strobe.
    cycle(1, 0, 0, 1);
    strobe(0, 1);
    strobe(0, 1);
    for (int i = 0; i < WIN; i++) begin
      strobe(1, 1);
      if (i == WIN - 2) check("t1_pre_valid", int'(code_valid), 0);
    end
    check("t1_lat_valid", int'(code_valid), 1);
    check("t1_code", int'(code), WIN);

    // Alternating bits: code=4 every window, windows back to back.
    for (int i = 0; i < 2 * WIN; i++) begin
      strobe(i % 2 == 0, 1);
      if (i % WIN == WIN - 1) begin
        check("t2_valid", int'(code_valid), 1);
        check("t2_code", int'(code), WIN / 2);
      end
    end
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);

    // Strobes while idle are ignored.
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 1);
    check("idle_busy", int'(busy), 0);

    // Consumer stalled over two windows: first code held, overrun set.
    cycle(1, 0, 0, 0);
    strobe(1, 0);
    strobe(1, 0);
    for (int i = 0; i < WIN; i++) begin
      b = 1'($urandom_range(0, 1));
      strobe(b, 0);
    end
    check("t3_ovr0", int'(overrun), 0);
    for (int i = 0; i < WIN; i++) begin
      b = 1'($urandom_range(0, 1));
      strobe(b, 0);
    end
    check("t3_ovr1", int'(overrun), 1);
    check("t3_hold_code", int'(code), m_last);
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    check("t3_ovr_sticky", int'(overrun), 1);
    cycle(1, 0, 0, 1);
    check("t3_ovr_clear", int'(overrun), 0);

    // Handshake in the same cycle as the next completion.
    strobe(0, 0);
    strobe(0, 0);
    for (int i = 0; i < WIN; i++) strobe(1, 0);
    for (int i = 0; i < WIN - 1; i++) strobe(i < 3, 0);
    strobe(0, 1);
    check("t4_valid", int'(code_valid), 1);
    check("t4_overrun", int'(overrun), 0);
    check("t4_code", int'(code), 3);
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);

    // Enable dropped on the 5th strobe of a window; partial window discarded.
    cycle(1, 0, 0, 1);
    strobe(1, 1);
    strobe(1, 1);
    for (int i = 0; i < WIN; i++) begin
      b = 1'($urandom_range(0, 1));
      strobe(b, 1);
    end
    for (int i = 0; i < 4; i++) strobe(1, 1);
    cycle(0, 1, 1, 1);
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 1);
    strobe(1, 1);
    strobe(1, 1);
    for (int i = 0; i < WIN - 1; i++) strobe(1, 1);
    check("t5_pre_valid", int'(code_valid), 0);
    strobe(1, 1);
    check("t5_post_valid", int'(code_valid), 1);
    check("t5_code", int'(code), WIN);

    // Asynchronous reset mid-window with a held code and overrun pending.
    for (int i = 0; i < WIN; i++) begin
      b = 1'($urandom_range(0, 1));
      strobe(b, 0);
    end
    for (int i = 0; i < 3; i++) strobe(1, 0);
    check("t6_pre_overrun", int'(overrun), 1);
    enable  = 1'b0;
    bit_stb = 1'b0;
    #1;
    reset_n = 1'b0;
    rst_evt = 1'b1;
    model_reset();
    #1;
    check("t6_code", int'(code), 0);
    check("t6_valid", int'(code_valid), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_overrun", int'(overrun), 0);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // First code after reset needs SETTLE + WIN strobes.
    cycle(1, 0, 0, 1);
    strobe(1, 1);
    strobe(1, 1);
    for (int i = 0; i < WIN - 1; i++) strobe(1, 1);
    check("t7_pre_valid", int'(code_valid), 0);
    strobe(1, 1);
    check("t7_post_valid", int'(code_valid), 1);
    check("t7_code", int'(code), WIN);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    check("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_tmp_decimator

// File: doc/tmp_decimator.md
TMP_DECIMATOR -- requirements
Module: tmp_decimator

Interface
REQ-001 Parameter OSR_LOG2, default 8, SHALL set the decimation window to 2^OSR_LOG2 comparator decisions.
REQ-002 Parameter SETTLE, default 4, SHALL set the number of leading decisions discarded after enable.
REQ-003 Parameter CODE_W, default OSR_LOG2+1, SHALL set the result width.
REQ-004 clk  input  1  sole clock; all logic on posedge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 enable  input  1  high = convert continuously; low = abort and idle.
REQ-007 bit_stb  input  1  one-cycle pulse marking a valid comparator decision from the sensor controller.
REQ-008 cmp_bit  input  1  comparator decision, sampled only when bit_stb=1.
REQ-009 code  output  CODE_W  count of ones in the last completed window.
REQ-010 code_valid  output  1  code holds an unconsumed result.
REQ-011 code_ready  input  1  consumer accepts code when code_valid & code_ready.
REQ-012 busy  output  1  high in SETTLE or ACCUM.
REQ-013 overrun  output  1  sticky: a completed window was dropped.

Function
REQ-014 FSM states SHALL be IDLE, SETTLE, ACCUM.
REQ-015 IDLE -> SETTLE when enable=1; settle counter and ones accumulator cleared on entry.
REQ-016 SETTLE: each bit_stb increments settle count; after SETTLE strobes -> ACCUM; SETTLE=0 goes straight to ACCUM.
REQ-017 ACCUM: each bit_stb increments the sample counter and adds cmp_bit to the CODE_W-bit accumulator.
REQ-018 On the strobe completing 2^OSR_LOG2 samples, the final sum (including that strobe's bit) SHALL be offered the next cycle; the accumulator and sample counter restart with no dropped strobe; state stays ACCUM.
REQ-019 Accumulator SHALL NOT wrap: range 0..2^OSR_LOG2 fits CODE_W bits exactly (all-ones window gives code=2^OSR_LOG2).
REQ-020 Handshake: code and code_valid SHALL be stable while code_valid=1 and code_ready=0; code_valid falls the cycle after a handshake unless a new result loads.
REQ-021 Result completes while code_valid=1 and code_ready=0: new result dropped, old code held, overrun set.
REQ-022 Result completes in the same cycle as a handshake: new result loaded, code_valid stays 1, no overrun.
REQ-023 enable=0 in any state: next state IDLE, partial window discarded, a bit_stb in that cycle ignored; held code/code_valid unaffected.
REQ-024 overrun SHALL clear on rising enable (IDLE -> SETTLE) and on reset only.
REQ-025 bit_stb in IDLE SHALL be ignored.

Reset
REQ-026 reset_n low SHALL immediately force: state IDLE, code=0, code_valid=0, busy=0, overrun=0, all counters 0.
REQ-027 Reset mid-window SHALL discard all partial and held results; first valid code after release needs SETTLE+2^OSR_LOG2 strobes.

Structure
REQ-028 Shared package tmp_pkg SHALL hold the state enum and default OSR_LOG2/SETTLE constants.
REQ-029 One sub-module tmp_ones_counter (strobe-gated count/accumulate with restart) SHALL hold counter and accumulator; FSM and handshake stay in tmp_decimator.

Verification
REQ-030 OSR_LOG2=3, SETTLE=2, enable=1, 10 strobes all cmp_bit=1, code_ready=1 -> code=8, code_valid one cycle after 10th strobe.
REQ-031 Same setup, alternating 1/0 after settle -> code=4 every window, no gap between windows.
REQ-032 code_ready held 0 across two windows -> first code held stable, overrun=1 after second window; re-enable clears overrun.
REQ-033 Handshake in same cycle as next completion -> code_valid stays 1, code updates, overrun=0.
REQ-034 enable dropped at 5th window strobe, re-raised -> no code for partial window; next code after SETTLE+8 strobes.
REQ-035 reset_n pulsed low between clock edges mid-window -> all outputs 0 immediately, asynchronous to clk.
